// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, MEM-stage
// exception flag positions, CP0 register addresses, stall bus and FSM encodings.
package except_ctrl_pkg;

  // Stall bus: one bit per pipeline stage, bit 4 freezes MEM.
  localparam int unsigned StallBusW   = 6;
  localparam int unsigned StallMemIdx = 4;
  typedef logic [StallBusW-1:0] stall_bus_t;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // CP0 register addresses seen on the WB write port.
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // STATUS bit positions used for interrupt qualification.
  localparam int unsigned StatusIe  = 0;
  localparam int unsigned StatusExl = 1;

  // Exception codes handed to CP0; zero means no event.
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Bit positions inside the MEM-stage exception flag vector.
  localparam int unsigned MemExcW     = 9;
  localparam int unsigned ExcAdelIf   = 0;
  localparam int unsigned ExcRi       = 1;
  localparam int unsigned ExcOv       = 2;
  localparam int unsigned ExcTrap     = 3;
  localparam int unsigned ExcSyscall  = 4;
  localparam int unsigned ExcBrk      = 5;
  localparam int unsigned ExcAdel     = 6;
  localparam int unsigned ExcAdes     = 7;
  localparam int unsigned ExcEret     = 8;

  // Controller FSM encoding.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StBlank = 2'd2;

  // An interrupt is requested when globally enabled, not already in an
  // exception level, and at least one pending line is unmasked.
  function automatic logic int_pending(input logic       ie,
                                       input logic       exl,
                                       input logic [7:0] im,
                                       input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Combinational exception arbiter: picks the highest-priority event among the
// interrupt request and the MEM-stage flags and supplies its code and bad address.
module exc_prio
  import except_ctrl_pkg::*;
(
  input  logic [MemExcW-1:0] exc_i,
  input  logic               int_req_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        vaddr_i,
  output logic               hit_o,
  output logic [31:0]        code_o,
  output logic [31:0]        bad_vaddr_o,
  output logic               is_eret_o
);

  // Fixed priority chain, interrupt first, ERET last.
  always_comb begin
    hit_o       = 1'b1;
    code_o      = '0;
    bad_vaddr_o = '0;
    is_eret_o   = 1'b0;
    if (int_req_i) begin
      code_o = EXC_INT;
    end else if (exc_i[ExcAdelIf]) begin
      code_o      = EXC_ADEL;
      bad_vaddr_o = pc_i;
    end else if (exc_i[ExcRi]) begin
      code_o = EXC_RI;
    end else if (exc_i[ExcOv]) begin
      code_o = EXC_OV;
    end else if (exc_i[ExcTrap]) begin
      code_o = EXC_TR;
    end else if (exc_i[ExcSyscall]) begin
      code_o = EXC_SYS;
    end else if (exc_i[ExcBrk]) begin
      code_o = EXC_BP;
    end else if (exc_i[ExcAdel]) begin
      code_o      = EXC_ADEL;
      bad_vaddr_o = vaddr_i;
    end else if (exc_i[ExcAdes]) begin
      code_o      = EXC_ADES;
      bad_vaddr_o = vaddr_i;
    end else if (exc_i[ExcEret]) begin
      code_o    = EXC_ERET;
      is_eret_o = 1'b1;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// Exception initiator: bypasses in-flight MTC0 writes, qualifies interrupts,
// arbitrates MEM-stage exceptions and issues one registered event per trap,
// followed by a blanking cycle.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic               clk,
  input  logic               rst,
  input  stall_bus_t         stall,
  input  logic               mem_valid,
  input  logic [31:0]        mem_pc,
  input  logic               mem_in_delayslot,
  input  logic [MemExcW-1:0] mem_exc,
  input  logic [31:0]        mem_vaddr,
  input  logic [5:0]         ext_int,
  input  logic               timer_int,
  input  logic [31:0]        cp0_status,
  input  logic [31:0]        cp0_cause,
  input  logic [31:0]        cp0_epc,
  input  logic               wb_cp0_we,
  input  logic [4:0]         wb_cp0_addr,
  input  logic [31:0]        wb_cp0_data,
  output logic [31:0]        excepttype_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        bad_vaddr_o,
  output logic               is_in_delayslot_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic [5:0]         int_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] excepttype_q, excepttype_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic        ds_q, ds_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  int_q, int_d;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_req;
  logic        eval_en;
  logic        take_exc;

  logic        sel_hit;
  logic [31:0] sel_code;
  logic [31:0] sel_bad_vaddr;
  logic        sel_is_eret;

  // Effective CP0 view: an MTC0 in WB overrides the architectural value; for
  // CAUSE only the software interrupt bits are writable.
  always_comb begin
    status_eff = cp0_status;
    cause_eff  = cp0_cause;
    epc_eff    = cp0_epc;
    if (wb_cp0_we) begin
      if (wb_cp0_addr == CP0_REG_STATUS) begin
        status_eff = wb_cp0_data;
      end
      if (wb_cp0_addr == CP0_REG_CAUSE) begin
        cause_eff[9:8] = wb_cp0_data[9:8];
      end
      if (wb_cp0_addr == CP0_REG_EPC) begin
        epc_eff = wb_cp0_data;
      end
    end
  end

  // Interrupt qualification and evaluation window. The request is level-based
  // on CP0 state, so a request blocked by a stall is retried automatically.
  always_comb begin
    int_req  = int_pending(status_eff[StatusIe], status_eff[StatusExl],
                           status_eff[15:8], cause_eff[15:8]);
    eval_en  = (state_q == StIdle) && mem_valid && (stall[StallMemIdx] == NoStop);
    take_exc = eval_en && sel_hit;
  end

  exc_prio u_exc_prio (
    .exc_i       (mem_exc),
    .int_req_i   (int_req),
    .pc_i        (mem_pc),
    .vaddr_i     (mem_vaddr),
    .hit_o       (sel_hit),
    .code_o      (sel_code),
    .bad_vaddr_o (sel_bad_vaddr),
    .is_eret_o   (sel_is_eret)
  );

  // FSM: IDLE -> FLUSH on an accepted event, then one BLANK cycle.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = take_exc ? StFlush : StIdle;
      StFlush: state_d = StBlank;
      StBlank: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next-state: event fields load only on acceptance, otherwise zero,
  // which also makes FLUSH last exactly one cycle and BLANK output nothing.
  always_comb begin
    excepttype_d = '0;
    pc_d         = '0;
    bad_vaddr_d  = '0;
    ds_d         = 1'b0;
    flush_d      = 1'b0;
    new_pc_d     = '0;
    if (take_exc) begin
      excepttype_d = sel_code;
      pc_d         = mem_pc;
      bad_vaddr_d  = sel_bad_vaddr;
      ds_d         = mem_in_delayslot;
      flush_d      = 1'b1;
      new_pc_d     = sel_is_eret ? epc_eff : EXC_VECTOR;
    end
    int_d = {ext_int[5] | timer_int, ext_int[4:0]};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      excepttype_q <= '0;
      pc_q         <= '0;
      bad_vaddr_q  <= '0;
      ds_q         <= 1'b0;
      flush_q      <= 1'b0;
      new_pc_q     <= '0;
      int_q        <= '0;
    end else begin
      state_q      <= state_d;
      excepttype_q <= excepttype_d;
      pc_q         <= pc_d;
      bad_vaddr_q  <= bad_vaddr_d;
      ds_q         <= ds_d;
      flush_q      <= flush_d;
      new_pc_q     <= new_pc_d;
      int_q        <= int_d;
    end
  end

  assign excepttype_o      = excepttype_q;
  assign pc_o              = pc_q;
  assign bad_vaddr_o       = bad_vaddr_q;
  assign is_in_delayslot_o = ds_q;
  assign flush_o           = flush_q;
  assign new_pc_o          = new_pc_q;
  assign int_o             = int_q;

  // Register bits that play no part in exception decisions.
  logic unused_ok;
  assign unused_ok = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0],
                       stall[5], stall[3:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Directed, table-driven bench for except_ctrl plus hand-written sequences for
// stall deferral, back-to-back events, int_o timing and reset during FLUSH.
module tb_except_ctrl;
  import except_ctrl_pkg::*;

  localparam logic [31:0] V = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  stall_bus_t  stall;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [8:0]  mem_exc;
  logic [31:0] mem_vaddr;
  logic [5:0]  ext_int;
  logic        timer_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_addr;
  logic [31:0] wb_cp0_data;
  logic [31:0] excepttype_o, pc_o, bad_vaddr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;
  logic [5:0]  int_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  except_ctrl #(.EXC_VECTOR(V)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .mem_valid         (mem_valid),
    .mem_pc            (mem_pc),
    .mem_in_delayslot  (mem_in_delayslot),
    .mem_exc           (mem_exc),
    .mem_vaddr         (mem_vaddr),
    .ext_int           (ext_int),
    .timer_int         (timer_int),
    .cp0_status        (cp0_status),
    .cp0_cause         (cp0_cause),
    .cp0_epc           (cp0_epc),
    .wb_cp0_we         (wb_cp0_we),
    .wb_cp0_addr       (wb_cp0_addr),
    .wb_cp0_data       (wb_cp0_data),
    .excepttype_o      (excepttype_o),
    .pc_o              (pc_o),
    .bad_vaddr_o       (bad_vaddr_o),
    .is_in_delayslot_o (is_in_delayslot_o),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .int_o             (int_o)
  );

  typedef struct packed {
    logic        valid;
    logic        stall4;
    logic [8:0]  exc;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        ds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_code;
    logic [31:0] e_pc;
    logic [31:0] e_bad;
    logic        e_ds;
    logic        e_flush;
    logic [31:0] e_newpc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall            = '0;
    mem_valid        = 1'b0;
    mem_pc           = '0;
    mem_in_delayslot = 1'b0;
    mem_exc          = '0;
    mem_vaddr        = '0;
    ext_int          = '0;
    timer_int        = 1'b0;
    cp0_status       = '0;
    cp0_cause        = '0;
    cp0_epc          = '0;
    wb_cp0_we        = 1'b0;
    wb_cp0_addr      = '0;
    wb_cp0_data      = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " code"}, excepttype_o, 32'h0);
    chk({tag, " pc"}, pc_o, 32'h0);
    chk({tag, " bad"}, bad_vaddr_o, 32'h0);
    chk({tag, " ds"}, {31'b0, is_in_delayslot_o}, 32'h0);
    chk({tag, " flush"}, {31'b0, flush_o}, 32'h0);
    chk({tag, " newpc"}, new_pc_o, 32'h0);
  endtask

  // excepttype_o must never be nonzero on two consecutive cycles.
  logic [31:0] prev_code = '0;
  always @(negedge clk) begin
    if (prev_code != 32'h0) chk("no_back_to_back", excepttype_o, 32'h0);
    prev_code <= excepttype_o;
  end

  initial begin
    // valid stall exc pc vaddr ds | status cause epc we waddr wdata
    //   | e_code e_pc e_bad e_ds e_flush e_newpc
    vecs[0]  = '{1'b1, 1'b0, 9'h010, 32'h8000_1000, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h8, 32'h8000_1000, 32'h0, 1'b0, 1'b1, V};
    vecs[1]  = '{1'b1, 1'b0, 9'h080, 32'h8000_1004, 32'h1003, 1'b1,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h5, 32'h8000_1004, 32'h1003, 1'b1, 1'b1, V};
    vecs[2]  = '{1'b1, 1'b0, 9'h005, 32'h2, 32'h77, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h4, 32'h2, 32'h2, 1'b0, 1'b1, V};
    vecs[3]  = '{1'b1, 1'b0, 9'h100, 32'h8000_0100, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h8000_0000, 1'b1, 5'd14, 32'h8000_2000,
                 32'he, 32'h8000_0100, 32'h0, 1'b0, 1'b1, 32'h8000_2000};
    vecs[4]  = '{1'b1, 1'b0, 9'h00a, 32'h8000_0200, 32'h44, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'ha, 32'h8000_0200, 32'h0, 1'b0, 1'b1, V};
    vecs[5]  = '{1'b1, 1'b0, 9'h01c, 32'h8000_0204, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'hc, 32'h8000_0204, 32'h0, 1'b0, 1'b1, V};
    vecs[6]  = '{1'b1, 1'b0, 9'h038, 32'h8000_0208, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'hd, 32'h8000_0208, 32'h0, 1'b0, 1'b1, V};
    vecs[7]  = '{1'b1, 1'b0, 9'h0e0, 32'h8000_0300, 32'h2000, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h9, 32'h8000_0300, 32'h0, 1'b0, 1'b1, V};
    vecs[8]  = '{1'b1, 1'b0, 9'h0c0, 32'h8000_0304, 32'h2001, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h4, 32'h8000_0304, 32'h2001, 1'b0, 1'b1, V};
    vecs[9]  = '{1'b1, 1'b0, 9'h180, 32'h8000_0308, 32'h3002, 1'b0,
                 32'h0, 32'h0, 32'h8000_0040, 1'b0, 5'd0, 32'h0,
                 32'h5, 32'h8000_0308, 32'h3002, 1'b0, 1'b1, V};
    vecs[10] = '{1'b1, 1'b0, 9'h100, 32'h8000_030c, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h8000_0040, 1'b1, 5'd12, 32'h0,
                 32'he, 32'h8000_030c, 32'h0, 1'b0, 1'b1, 32'h8000_0040};
    vecs[11] = '{1'b1, 1'b0, 9'h010, 32'h8000_0400, 32'h0, 1'b1,
                 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h1, 32'h8000_0400, 32'h0, 1'b1, 1'b1, V};
    vecs[12] = '{1'b1, 1'b0, 9'h000, 32'h8000_0404, 32'h0, 1'b0,
                 32'h401, 32'h400, 32'h0, 1'b1, 5'd12, 32'h400,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 9'h000, 32'h8000_0500, 32'h0, 1'b0,
                 32'h101, 32'h0, 32'h0, 1'b1, 5'd13, 32'h100,
                 32'h1, 32'h8000_0500, 32'h0, 1'b0, 1'b1, V};
    vecs[14] = '{1'b1, 1'b0, 9'h000, 32'h8000_0504, 32'h0, 1'b0,
                 32'h401, 32'h0, 32'h0, 1'b1, 5'd13, 32'h400,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 9'h000, 32'h8000_0508, 32'h0, 1'b0,
                 32'h403, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 1'b1, 9'h010, 32'h8000_050c, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 9'h010, 32'h8000_0510, 32'h0, 1'b0,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 1'b0, 9'h000, 32'h8000_0514, 32'h1234, 1'b1,
                 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 9'h000, 32'h8000_0518, 32'h0, 1'b0,
                 32'h801, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[20] = '{1'b1, 1'b0, 9'h000, 32'h8000_0800, 32'h0, 1'b0,
                 32'h0, 32'h400, 32'h0, 1'b1, 5'd12, 32'h401,
                 32'h1, 32'h8000_0800, 32'h0, 1'b0, 1'b1, V};

    // Reset state, with interrupt lines active to show int_o is held low.
    drive_idle();
    ext_int   = 6'h3f;
    timer_int = 1'b1;
    rst       = 1'b0;
    #22;
    chk_zero("reset");
    chk("reset int_o", {26'b0, int_o}, 32'h0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);

    // Table: drive for one cycle, check the FLUSH cycle, then the BLANK cycle.
    for (int i = 0; i < NV; i++) begin
      mem_valid        = vecs[i].valid;
      stall            = '0;
      stall[4]         = vecs[i].stall4 ? Stop : 1'b0;
      mem_exc          = vecs[i].exc;
      mem_pc           = vecs[i].pc;
      mem_vaddr        = vecs[i].vaddr;
      mem_in_delayslot = vecs[i].ds;
      cp0_status       = vecs[i].status;
      cp0_cause        = vecs[i].cause;
      cp0_epc          = vecs[i].epc;
      wb_cp0_we        = vecs[i].we;
      wb_cp0_addr      = vecs[i].waddr;
      wb_cp0_data      = vecs[i].wdata;
      @(negedge clk);
      drive_idle();
      chk($sformatf("v%0d code", i), excepttype_o, vecs[i].e_code);
      chk($sformatf("v%0d pc", i), pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d bad", i), bad_vaddr_o, vecs[i].e_bad);
      chk($sformatf("v%0d ds", i), {31'b0, is_in_delayslot_o}, {31'b0, vecs[i].e_ds});
      chk($sformatf("v%0d flush", i), {31'b0, flush_o}, {31'b0, vecs[i].e_flush});
      chk($sformatf("v%0d newpc", i), new_pc_o, vecs[i].e_newpc);
      @(negedge clk);
      chk_zero($sformatf("v%0d blank", i));
      @(negedge clk);
    end

    // int_o is a one-cycle registered copy, bit 5 merges the timer.
    ext_int   = 6'b000010;
    timer_int = 1'b1;
    #1;
    chk("int_o before edge", {26'b0, int_o}, 32'h0);
    @(negedge clk);
    chk("int_o timer merge", {26'b0, int_o}, 32'h22);
    ext_int   = 6'b100000;
    timer_int = 1'b0;
    @(negedge clk);
    chk("int_o ext5", {26'b0, int_o}, 32'h20);
    drive_idle();
    @(negedge clk);
    chk("int_o clear", {26'b0, int_o}, 32'h0);

    // Interrupt held off by a MEM stall, taken once the stall releases.
    cp0_status = 32'h0000_0401;
    cp0_cause  = 32'h0000_0400;
    ext_int    = 6'b000001;
    mem_valid  = 1'b1;
    mem_pc     = 32'h8000_0600;
    stall[4]   = Stop;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d code", c), excepttype_o, 32'h0);
      chk($sformatf("stall%0d int_o0", c), {31'b0, int_o[0]}, 32'h1);
    end
    stall = '0;
    @(negedge clk);
    chk("unstall code", excepttype_o, 32'h1);
    chk("unstall pc", pc_o, 32'h8000_0600);
    chk("unstall flush", {31'b0, flush_o}, 32'h1);
    chk("unstall newpc", new_pc_o, V);
    drive_idle();
    @(negedge clk);
    @(negedge clk);

    // Same sequence with EXL set: nothing may be taken.
    cp0_status = 32'h0000_0403;
    cp0_cause  = 32'h0000_0400;
    ext_int    = 6'b000001;
    mem_valid  = 1'b1;
    mem_pc     = 32'h8000_0610;
    stall[4]   = Stop;
    repeat (3) @(negedge clk);
    stall = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("exl%0d code", c), excepttype_o, 32'h0);
      chk($sformatf("exl%0d flush", c), {31'b0, flush_o}, 32'h0);
    end
    drive_idle();
    @(negedge clk);

    // Syscall held two cycles: one event, second cycle blanked.
    mem_valid = 1'b1;
    mem_exc   = 9'h010;
    mem_pc    = 32'h8000_0900;
    @(negedge clk);
    chk("b2b first code", excepttype_o, 32'h8);
    chk("b2b first pc", pc_o, 32'h8000_0900);
    @(negedge clk);
    drive_idle();
    chk_zero("b2b second");
    @(negedge clk);
    chk("b2b after code", excepttype_o, 32'h0);

    // Reset asserted during FLUSH truncates the pulse immediately.
    mem_valid = 1'b1;
    mem_exc   = 9'h010;
    mem_pc    = 32'h8000_0a00;
    @(negedge clk);
    chk("rstflush pre flush", {31'b0, flush_o}, 32'h1);
    drive_idle();
    #1;
    rst = 1'b0;
    #1;
    chk_zero("rstflush");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstflush after code", excepttype_o, 32'h0);
    mem_valid = 1'b1;
    mem_exc   = 9'h020;
    mem_pc    = 32'h8000_0a04;
    @(negedge clk);
    chk("rstflush idle code", excepttype_o, 32'h9);
    chk("rstflush idle pc", pc_o, 32'h8000_0a04);
    drive_idle();
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception initiator for the CP0 register file. Examines the instruction leaving the MEM stage, merges sampled external and timer interrupts, arbitrates by priority and presents one registered exception event per trap to CP0 (`excepttype`, `pc`, `bad_vaddr`, `is_in_delayslot`). In the same cycle it drives the pipeline flush and redirect PC, then blanks squashed younger instructions for one cycle. It sits between the MEM stage, the stall controller and `cp0_reg`.

## Interface
- `EXC_VECTOR`, default 32'hBFC00380: redirect target for every non-ERET event.
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-low.
- `stall` input `StallBus`: stall vector; `stall[4]==Stop` freezes MEM.
- `mem_valid` input 1: MEM holds a real instruction.
- `mem_pc` input 32: PC of the MEM instruction.
- `mem_in_delayslot` input 1: MEM instruction sits in a delay slot.
- `mem_exc` input 9: flags {eret, ades, adel, brk, syscall, trap, ov, ri, adel_if}, bit 0 = adel_if.
- `mem_vaddr` input 32: data address of the load or store.
- `ext_int` input 6: raw external interrupt lines.
- `timer_int` input 1: timer interrupt from CP0.
- `cp0_status`, `cp0_cause`, `cp0_epc` input 32 each: current CP0 register values.
- `wb_cp0_we` input 1, `wb_cp0_addr` input 5, `wb_cp0_data` input 32: in-flight MTC0 write.
- `excepttype_o` output 32: code to CP0. 0 means no event.
- `pc_o` output 32: faulting PC.
- `bad_vaddr_o` output 32: faulting address.
- `is_in_delayslot_o` output 1: delay-slot flag of the faulting instruction.
- `flush_o` output 1: pipeline flush, one-cycle pulse.
- `new_pc_o` output 32: fetch redirect target, valid while `flush_o` is high.
- `int_o` output 6: registered interrupt lines to CP0 `int_i`. Bit 5 = `ext_int[5] | timer_int`.

## Operation
- Effective CP0 values: if `wb_cp0_we` is set and `wb_cp0_addr` matches STATUS (12), CAUSE (13) or EPC (14), that register's effective value is `wb_cp0_data`.
  - For CAUSE, only bits 9:8 are replaced.
  - Otherwise the effective value is the `cp0_*` input.
- Interrupt request = `status.IE` & !`status.EXL` & |(`cause[15:8]` & `status[15:8]`), all from effective values.
- Evaluation is enabled when: state is IDLE, `mem_valid`, and `stall[4]==NoStop`.
- Priority, highest first, with the event code and bad address for each:
  - interrupt: code 0x1
  - adel_if: code 0x4, bad = `mem_pc`
  - ri: code 0xa
  - ov: code 0xc
  - trap: code 0xd
  - syscall: code 0x8
  - brk: code 0x9
  - adel: code 0x4, bad = `mem_vaddr`
  - ades: code 0x5, bad = `mem_vaddr`
  - eret: code 0xe
- Non-bad-address events drive `bad_vaddr_o` = 0.
- `new_pc_o` = effective EPC for code 0xe, otherwise `EXC_VECTOR`.
- States:
  - IDLE: if evaluation is enabled and an event is selected, register the outputs and go to FLUSH.
  - FLUSH: outputs valid for this single cycle. Go to BLANK unconditionally.
  - BLANK: all MEM inputs are ignored and outputs are 0. Go to IDLE.
- An interrupt that arrives while MEM is stalled, invalid, or in FLUSH/BLANK is not lost. It is taken at the first enabled IDLE cycle in which the request is still true.

## Timing
- Reset (async assert, `rst`=0) sets everything to zero and the state to IDLE:
  - all outputs = 0, including `new_pc_o` and `int_o`;
  - state = IDLE.
  - Deassertion is synchronous to `clk`.
- `int_o` is `ext_int`/`timer_int` registered by one cycle, always, regardless of state.
- Latency:
  - Event detected in cycle T.
  - In cycle T+1, `flush_o`=1 together with `excepttype_o`, `pc_o`, `bad_vaddr_o`, `is_in_delayslot_o` and `new_pc_o`. CP0 samples at the end of T+1.
  - In cycle T+2 all outputs are 0 (BLANK).
- `excepttype_o` is never nonzero for two consecutive cycles.
- Reset asserted during FLUSH: the pulse is truncated immediately, with no event delivered.
- Same-cycle MTC0 EPC in WB and ERET in MEM: `new_pc_o` = `wb_cp0_data`.
- Same-cycle MTC0 STATUS with IE=0 and a pending interrupt: the interrupt is not taken.
- `stall[4]==Stop` while in IDLE: no event, even if flags are set. The flags are re-evaluated once the stall releases.

## Structure
- In `lib/defines.vh`:
  - exception codes: `EXC_INT`, `EXC_ADEL`, `EXC_ADES`, `EXC_SYS`, `EXC_BP`, `EXC_RI`, `EXC_OV`, `EXC_TR`, `EXC_ERET`;
  - `mem_exc` bit indices;
  - reuse of the existing `CP0_REG_*`, `Stop`/`NoStop` and `StallBus` definitions.
- One combinational sub-module, `exc_prio`: takes the flags, interrupt request, PC and vaddr, and returns {hit, code, bad_vaddr, is_eret}.
- `except_ctrl` holds the bypass, the interrupt qualification, the 3-state FSM and the output registers.

## Test plan
- Syscall, plain instruction: `mem_exc`=syscall, `mem_pc`=0x8000_1000, not stalled → next cycle `excepttype_o`=0x8, `pc_o`=0x8000_1000, `flush_o`=1, `new_pc_o`=0xBFC0_0380; all outputs 0 the following cycle.
- Delay-slot store fault: ades, `mem_vaddr`=0x1003, `mem_in_delayslot`=1 → code 0x5, `bad_vaddr_o`=0x1003, `is_in_delayslot_o`=1.
- Priority: adel_if and ov both set, `mem_pc`=0x2 → code 0x4, `bad_vaddr_o`=0x2.
- Interrupt deferred across a stall:
  - setup: status=0x0000_0401, `ext_int[0]`=1;
  - hold `stall[4]=Stop` for 3 cycles → no event, `int_o[0]`=1;
  - release the stall → code 0x1.
  - Repeat with EXL=1 → no event.
- ERET with WB bypass: ERET in MEM, WB MTC0 EPC=0x8000_2000, `cp0_epc`=0x8000_0000 → code 0xe, `new_pc_o`=0x8000_2000.
- Back-to-back and reset:
  - syscall in MEM for two consecutive cycles → only one event; the second cycle is blanked;
  - `rst` low during FLUSH → all outputs 0 immediately.
